// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: execute-stage inputs, data-memory bus, write-back,
// branch-redirect and fault signals of the MEM pipeline stage.
// slave = the stage controller's view, master = the surrounding pipeline/memory.
interface mem_stage_ctrl_if #(
    parameter int WORD = 64
);
    logic            ex_valid;
    logic [WORD-1:0] alu_result;
    logic [WORD-1:0] branch_target;
    logic [WORD-1:0] write_data;
    logic            zero;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            mem_req;
    logic            mem_we;
    logic [WORD-1:0] mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic            mem_ack;
    logic [WORD-1:0] mem_rdata;
    logic            stall;
    logic            wb_valid;
    logic [WORD-1:0] wb_data;
    logic [WORD-1:0] wb_alu_result;
    logic            pc_src;
    logic [WORD-1:0] pc_target;
    logic            bus_error;
    logic            align_fault;

    modport slave (
        input  ex_valid, alu_result, branch_target, write_data,
               zero, branch, mem_read, mem_write, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall,
               wb_valid, wb_data, wb_alu_result, pc_src, pc_target,
               bus_error, align_fault
    );

    modport master (
        output ex_valid, alu_result, branch_target, write_data,
               zero, branch, mem_read, mem_write, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall,
               wb_valid, wb_data, wb_alu_result, pc_src, pc_target,
               bus_error, align_fault
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage controller. Issues one data-memory
// request per load/store, stalls upstream while waiting for mem_ack, bounds
// the wait with a TIMEOUT-cycle counter (bus_error on expiry) and produces a
// one-cycle write-back pulse plus a registered branch redirect.
// Optional feature macro: MISALIGN_TRAP_EN (trap memops whose address is not
// 8-byte aligned with an align_fault pulse instead of issuing them).
module mem_stage_ctrl #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_stage_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [WORD-1:0] mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic [WORD-1:0] wb_data_q, wb_data_d;
    logic [WORD-1:0] wb_alu_q, wb_alu_d;
    logic            pc_src_q, pc_src_d;
    logic [WORD-1:0] pc_target_q, pc_target_d;
    logic            bus_error_q, bus_error_d;
    logic            align_fault_q, align_fault_d;
    logic            stall_c;
    logic            memop;
    logic            misalign;

    assign memop = bus.ex_valid & (bus.mem_read | bus.mem_write);

`ifdef MISALIGN_TRAP_EN
    assign misalign = memop & (|bus.alu_result[2:0]);
`else
    assign misalign = 1'b0;
`endif

    // Next-state, request latch, write-back and fault-pulse computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_alu_d      = wb_alu_q;
        pc_src_d      = 1'b0;
        pc_target_d   = '0;
        bus_error_d   = 1'b0;
        align_fault_d = 1'b0;
        stall_c       = 1'b0;
        case (state_q)
            IDLE: begin
                pc_src_d = bus.ex_valid & bus.branch & bus.zero;
                if (bus.ex_valid && bus.branch) begin
                    pc_target_d = bus.branch_target;
                end
                if (misalign) begin
                    align_fault_d = 1'b1;
                end else if (memop) begin
                    stall_c     = 1'b1;
                    state_d     = WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    // mem_write wins when both control bits are set
                    mem_we_d    = bus.mem_write;
                    mem_addr_d  = bus.alu_result;
                    mem_wdata_d = bus.write_data;
                end else if (bus.ex_valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = bus.alu_result;
                    wb_alu_d   = bus.alu_result;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mem_we_q ? mem_addr_q : bus.mem_rdata;
                    wb_alu_d   = mem_addr_q;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        bus_error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_alu_q      <= '0;
            pc_src_q      <= 1'b0;
            pc_target_q   <= '0;
            bus_error_q   <= 1'b0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_alu_q      <= wb_alu_d;
            pc_src_q      <= pc_src_d;
            pc_target_q   <= pc_target_d;
            bus_error_q   <= bus_error_d;
            align_fault_q <= align_fault_d;
        end
    end

    // stall is combinational but must read 0 the instant reset is raised.
    assign bus.stall         = stall_c & ~reset;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_alu_result = wb_alu_q;
    assign bus.pc_src        = pc_src_q;
    assign bus.pc_target     = pc_target_q;
    assign bus.bus_error     = bus_error_q;
    assign bus.align_fault   = align_fault_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl (WORD=64, TIMEOUT=16).
// Expected write-back results are queued when an instruction is driven and
// popped by a negedge monitor whenever wb_valid is seen.
module tb_mem_stage_ctrl;
    localparam int W  = 64;
    localparam int TO = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] alu;
    } exp_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    mem_stage_ctrl_if #(.WORD(W)) bus ();

    mem_stage_ctrl #(.WORD(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write-back monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.wb_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got wb_valid=1 data=%h, want no write-back", bus.wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.wb_data, bus.wb_alu_result} !== {e.data, e.alu}) begin
                    bad++;
                    $display("FAIL wb_data: got data=%h alu=%h, want data=%h alu=%h",
                             bus.wb_data, bus.wb_alu_result, e.data, e.alu);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.ex_valid      = 1'b0;
        bus.alu_result    = '0;
        bus.branch_target = '0;
        bus.write_data    = '0;
        bus.zero          = 1'b0;
        bus.branch        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_ex();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        // memop presented during reset must not raise stall
        bus.ex_valid   = 1'b1;
        bus.mem_read   = 1'b1;
        bus.alu_result = 64'h100;
        #12;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.stall, bus.wb_valid, bus.pc_src, bus.bus_error, bus.align_fault} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {bus.mem_req, bus.mem_we, bus.stall, bus.wb_valid, bus.pc_src, bus.bus_error, bus.align_fault});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_alu_result, bus.pc_target} !== '0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h wb=%h alu=%h tgt=%h, want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_alu_result, bus.pc_target);
        end
        clear_ex();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu();
        bus.ex_valid   = 1'b1;
        bus.alu_result = 64'h2A;
        sb.push_back('{data: 64'h2A, alu: 64'h2A});
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall: got %b, want 0", bus.stall);
        end
        step();
        clear_ex();
        total++;
        if ({bus.wb_valid, bus.stall} !== 2'b10) begin
            bad++;
            $display("FAIL alu_wb: got wb_valid,stall=%b, want 10", {bus.wb_valid, bus.stall});
        end
        step();
        total++;
        if (bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL alu_wb_pulse: got %b, want 0", bus.wb_valid);
        end
    endtask

    // Issue one memop; mem_ack arrives in WAIT cycle ack_at (0 = never).
    task automatic do_mem(input logic [W-1:0] addr, input logic [W-1:0] wdata,
                          input logic [W-1:0] rdata, input logic rd, input logic wr,
                          input int unsigned ack_at, output int unsigned req_cycles);
        req_cycles     = 0;
        bus.ex_valid   = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.alu_result = addr;
        bus.write_data = wdata;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL mem_accept_stall: got %b, want 1", bus.stall);
        end
        step();
        clear_ex();
        for (int unsigned c = 1; c <= 40 && bus.mem_req === 1'b1; c++) begin
            req_cycles++;
            total++;
            if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {addr, wdata, wr}) begin
                bad++;
                $display("FAIL mem_req_stable: got addr=%h wdata=%h we=%b, want addr=%h wdata=%h we=%b",
                         bus.mem_addr, bus.mem_wdata, bus.mem_we, addr, wdata, wr);
            end
            if (c == ack_at) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                sb.push_back('{data: (wr ? addr : rdata), alu: addr});
                #1;
                total++;
                if (bus.stall !== 1'b0) begin
                    bad++;
                    $display("FAIL mem_ack_stall: got %b, want 0", bus.stall);
                end
            end
            step();
            bus.mem_ack = 1'b0;
        end
        if (ack_at != 0) begin
            total++;
            if ({bus.mem_req, bus.wb_valid, bus.bus_error} !== 3'b010) begin
                bad++;
                $display("FAIL mem_done: got req,wb_valid,bus_error=%b, want 010",
                         {bus.mem_req, bus.wb_valid, bus.bus_error});
            end
        end
    endtask

    task automatic test_load();
        int unsigned n;
        do_mem(64'h100, 64'h0, 64'hDEAD, 1'b1, 1'b0, 3, n);
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL load_req_cycles: got %0d, want 3", n);
        end
        step();
    endtask

    task automatic test_store();
        int unsigned n;
        do_mem(64'h108, 64'h55, 64'hBEEF, 1'b0, 1'b1, 1, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL store_req_cycles: got %0d, want 1", n);
        end
        // read+write together is a store
        do_mem(64'h200, 64'h66, 64'h77, 1'b1, 1'b1, 2, n);
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL rw_req_cycles: got %0d, want 2", n);
        end
        step();
    endtask

    task automatic test_ack_idle();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hBAD;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.mem_req, bus.wb_valid, bus.stall} !== 3'b000) begin
                bad++;
                $display("FAIL ack_idle: got req,wb_valid,stall=%b, want 000",
                         {bus.mem_req, bus.wb_valid, bus.stall});
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_branch();
        bus.ex_valid = 1'b1; bus.branch = 1'b1; bus.zero = 1'b1;
        bus.branch_target = 64'h400; bus.alu_result = 64'h10;
        sb.push_back('{data: 64'h10, alu: 64'h10});
        step();
        clear_ex();
        total++;
        if ({bus.pc_src, bus.pc_target} !== {1'b1, 64'h400}) begin
            bad++;
            $display("FAIL br_taken: got pc_src=%b tgt=%h, want 1 400", bus.pc_src, bus.pc_target);
        end
        step();
        total++;
        if ({bus.pc_src, bus.pc_target} !== {1'b0, 64'h0}) begin
            bad++;
            $display("FAIL br_clear: got pc_src=%b tgt=%h, want 0 0", bus.pc_src, bus.pc_target);
        end
        bus.ex_valid = 1'b1; bus.branch = 1'b1; bus.zero = 1'b0;
        bus.branch_target = 64'h400; bus.alu_result = 64'h20;
        sb.push_back('{data: 64'h20, alu: 64'h20});
        step();
        clear_ex();
        total++;
        if (bus.pc_src !== 1'b0) begin
            bad++;
            $display("FAIL br_not_taken: got pc_src=%b, want 0", bus.pc_src);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] tg [2];
        tg[0] = 64'h500;
        tg[1] = 64'h600;
        for (int i = 0; i < 2; i++) begin
            bus.ex_valid = 1'b1; bus.branch = 1'b1; bus.zero = 1'b1;
            bus.branch_target = tg[i]; bus.alu_result = 64'h30 + 64'(i);
            sb.push_back('{data: 64'h30 + 64'(i), alu: 64'h30 + 64'(i)});
            step();
            total++;
            if ({bus.pc_src, bus.pc_target, bus.wb_valid} !== {1'b1, tg[i], 1'b1}) begin
                bad++;
                $display("FAIL b2b_%0d: got pc_src=%b tgt=%h wb_valid=%b, want 1 %h 1",
                         i, bus.pc_src, bus.pc_target, bus.wb_valid, tg[i]);
            end
        end
        clear_ex();
        step();
    endtask

    task automatic test_timeout();
        int unsigned n;
        do_mem(64'h180, 64'h0, 64'h0, 1'b1, 1'b0, 0, n);
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d, want %0d", n, TO);
        end
        total++;
        if ({bus.bus_error, bus.wb_valid, bus.stall} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_err: got bus_error,wb_valid,stall=%b, want 100",
                     {bus.bus_error, bus.wb_valid, bus.stall});
        end
        step();
        total++;
        if (bus.bus_error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: got %b, want 0", bus.bus_error);
        end
        // ack in the final counted cycle still completes normally
        do_mem(64'h188, 64'h0, 64'h1234, 1'b1, 1'b0, TO, n);
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL ack_at_timeout_cycles: got %0d, want %0d", n, TO);
        end
        step();
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        bus.ex_valid = 1'b1; bus.mem_read = 1'b1; bus.alu_result = 64'h103;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL misalign_stall: got %b, want 0", bus.stall);
        end
        step();
        clear_ex();
        total++;
        if ({bus.align_fault, bus.mem_req, bus.wb_valid} !== 3'b100) begin
            bad++;
            $display("FAIL misalign_fault: got fault,req,wb_valid=%b, want 100",
                     {bus.align_fault, bus.mem_req, bus.wb_valid});
        end
        step();
        total++;
        if (bus.align_fault !== 1'b0) begin
            bad++;
            $display("FAIL misalign_pulse: got %b, want 0", bus.align_fault);
        end
`else
        int unsigned n;
        do_mem(64'h103, 64'h9, 64'hCAFE, 1'b1, 1'b0, 2, n);
        total++;
        if ({n, bus.align_fault} !== {32'd2, 1'b0}) begin
            bad++;
            $display("FAIL unaligned_issue: got cycles=%0d fault=%b, want 2 0", n, bus.align_fault);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid_wait();
        bus.ex_valid = 1'b1; bus.mem_write = 1'b1;
        bus.alu_result = 64'h140; bus.write_data = 64'hAB;
        step();
        clear_ex();
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.stall, bus.wb_valid, bus.bus_error, bus.mem_addr, bus.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_mid_wait: got req=%b we=%b stall=%b wb=%b err=%b addr=%h wdata=%h, want all 0",
                     bus.mem_req, bus.mem_we, bus.stall, bus.wb_valid, bus.bus_error, bus.mem_addr, bus.mem_wdata);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < TO + 2; i++) begin
            step();
            total++;
            if ({bus.mem_req, bus.bus_error, bus.wb_valid} !== 3'b000) begin
                bad++;
                $display("FAIL after_reset_%0d: got req,err,wb_valid=%b, want 000",
                         i, {bus.mem_req, bus.bus_error, bus.wb_valid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ack_idle();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        step();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending write-backs, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter WORD, default 64: datapath width.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles for mem_ack.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ex_valid, input, 1: the execute-stage outputs are valid this cycle.
REQ-006 SHALL have alu_result/branch_target/write_data, input, WORD each: execute results and store data (register read_data2).
REQ-007 SHALL have zero/branch/mem_read/mem_write, input, 1 each: ALU zero flag and control bits.
REQ-008 SHALL have mem_req/mem_we, output, 1 each, and mem_addr/mem_wdata, output, WORD each: data-memory request.
REQ-009 SHALL have mem_ack, input, 1, and mem_rdata, input, WORD: memory completion and load data.
REQ-010 SHALL have stall, output, 1: holds upstream stages.
REQ-011 SHALL have wb_valid, output, 1, and wb_data/wb_alu_result, output, WORD each: write-back register.
REQ-012 SHALL have pc_src, output, 1, and pc_target, output, WORD: registered branch redirect.
REQ-013 SHALL have bus_error and align_fault, output, 1 each: one-cycle fault pulses.

Function
REQ-014 SHALL implement an FSM with two states: IDLE and WAIT.
REQ-015 An instruction is memop when ex_valid & (mem_read | mem_write); it is accepted in IDLE only.
REQ-016 Non-memop with ex_valid in IDLE: next edge sets wb_valid=1 and wb_data=wb_alu_result=alu_result; stall stays 0.
REQ-017 pc_src SHALL register ex_valid & branch & zero at the acceptance edge; pc_target SHALL register branch_target; both SHALL be cleared the following cycle unless another branch is accepted.
REQ-018 Memop in IDLE: stall=1 combinationally; next edge enters WAIT and latches mem_addr=alu_result, mem_wdata=write_data, mem_we=mem_write, mem_req=1.
REQ-019 In WAIT, mem_req/addr/wdata/we SHALL stay stable until the mem_ack cycle; stall=1 except in the mem_ack cycle.
REQ-020 A mem_ack in WAIT: next edge clears mem_req, returns to IDLE, sets wb_valid=1, and sets wb_data=mem_rdata for loads or the latched address for stores; wb_alu_result SHALL equal the latched address.
REQ-021 The timeout counter SHALL reset to 0 on WAIT entry and increment each WAIT cycle without mem_ack.
REQ-022 If the counter reaches TIMEOUT-1 without mem_ack, the next edge clears mem_req, returns to IDLE, and pulses bus_error for one cycle; wb_valid SHALL be 0.
REQ-023 mem_ack SHALL be ignored in IDLE; mem_ack in the timeout cycle SHALL win as a normal completion.
REQ-024 wb_valid SHALL be 1 for exactly one cycle per completed instruction, and 0 otherwise.
REQ-025 If both mem_read and mem_write are set, the access SHALL be treated as a store.

Reset
REQ-026 reset SHALL immediately force state=IDLE, counter=0, and all outputs to 0 (mem_req, mem_we, mem_addr, mem_wdata, stall, wb_*, pc_*, bus_error, align_fault).
REQ-027 Reset in WAIT SHALL abandon the request with no wb_valid and no bus_error.

Configuration
REQ-028 With MISALIGN_TRAP_EN defined, a memop with alu_result[2:0]!=0 in IDLE SHALL issue no request and assert no stall; the next edge pulses align_fault and leaves wb_valid=0.
REQ-029 Without MISALIGN_TRAP_EN, align_fault SHALL be tied to 0 and the unaligned address SHALL be issued unchanged.

Verification
REQ-030 Scenario: non-memop, alu_result=0x2A -> wb_valid=1 with wb_data=0x2A one cycle later; stall never asserted.
REQ-031 Scenario: load to addr 0x100, mem_ack after 3 WAIT cycles with rdata=0xDEAD -> mem_req held 3 cycles; wb_data=0xDEAD; stall low in the ack cycle.
REQ-032 Scenario: store to 0x108 with data 0x55 -> mem_we=1 and mem_wdata=0x55 for the request; wb_data=0x108.
REQ-033 Scenario: CBZ with zero=1 and target 0x400 -> pc_src=1 and pc_target=0x400 for one cycle; zero=0 -> pc_src=0.
REQ-034 Scenario: load with no ack and TIMEOUT=16 -> bus_error pulses after 16 WAIT cycles; back to IDLE; no wb_valid.
REQ-035 Scenario: load to 0x103 with MISALIGN_TRAP_EN -> align_fault pulse and no mem_req; reset asserted mid-WAIT -> all outputs 0 immediately.
